// File: rtl/gbe_udp_pkg.sv
// Shared constants, packet descriptor type and IPv4 header checksum for the
// UDP/IPv4/Ethernet transmit framer.
package gbe_udp_pkg;

  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;
  localparam int HDR_LEN     = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
  localparam int MIN_FRAME   = 60;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  typedef struct packed {
    logic [31:0] destip;
    logic [15:0] destport;
    logic [15:0] len;
  } udp_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACKWAIT,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD
  } tx_state_e;

  // Ones'-complement sum of the ten IPv4 header words (checksum word as 0),
  // folded twice so any carry out of the first fold is absorbed.
  function automatic logic [15:0] ip_csum(input logic [15:0] id,
                                          input logic [15:0] totlen,
                                          input logic [31:0] src_ip,
                                          input logic [31:0] dst_ip);
    logic [19:0] sum;
    logic [16:0] fold;
    logic [15:0] res;
    sum = {4'h0, 16'h4500} + {4'h0, totlen} + {4'h0, id} + {4'h0, 16'h4000}
        + {4'h0, 8'h40, IP_PROTO_UDP}
        + {4'h0, src_ip[31:16]} + {4'h0, src_ip[15:0]}
        + {4'h0, dst_ip[31:16]} + {4'h0, dst_ip[15:0]};
    fold = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    res  = fold[15:0] + {15'h0, fold[16]};
    return ~res;
  endfunction

endpackage

// File: rtl/gbe_udp_fifo.sv
// Generic first-word-fall-through synchronous FIFO: rd_data always shows the
// head entry; rd_en consumes it. Writes when full and reads when empty are ignored.
module gbe_udp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign count   = wr_ptr - rd_ptr;
  assign full    = count[AW];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/gbe_udp_core.sv
// Store-and-forward UDP/IPv4/Ethernet TX framer: buffers application packets,
// then streams header + payload (+ pad) to a byte-wide MAC with dvld/ack.
module gbe_udp_core
  import gbe_udp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC    = 48'h123456789abc,
  parameter logic [31:0] LOCAL_IP     = {8'd100, 8'd101, 8'd102, 8'd103},
  parameter logic [15:0] LOCAL_PORT   = 16'hdead,
  parameter logic [47:0] DEST_MAC     = 48'hffffffffffff,
  parameter int          DATA_DEPTH   = 2048,
  parameter int          HDR_DEPTH    = 8,
  parameter int          AFULL_MARGIN = 64,
  parameter int          MAX_PAYLOAD  = 1472
) (
  input  logic        app_clk,
  input  logic        app_rst_n,
  input  logic [7:0]  app_tx_data,
  input  logic        app_tx_dvld,
  input  logic        app_tx_eof,
  input  logic [31:0] app_tx_destip,
  input  logic [15:0] app_tx_destport,
  output logic        app_tx_afull,
  output logic        app_tx_overflow,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int HAW = $clog2(HDR_DEPTH);
  localparam logic [DAW:0] DATA_DEPTH_W = (DAW+1)'(DATA_DEPTH);
  localparam logic [15:0]  IP_UDP_OVH   = 16'(IP_HDR_LEN + UDP_HDR_LEN);
  localparam logic [15:0]  UDP_OVH      = 16'(UDP_HDR_LEN);

  // ---------------- buffers ----------------
  logic [DAW:0] data_count;
  logic         data_full;
  logic         data_rd;
  logic [7:0]   data_head;
  logic [HAW:0] hdr_count;
  logic         hdr_full;
  logic         hdr_empty;
  logic         hdr_rd;
  logic         hdr_wr;
  udp_desc_t    hdr_wr_data;
  udp_desc_t    hdr_head;

  // ---------------- ingress ----------------
  logic [15:0]  in_len;
  logic [15:0]  len_inc;
  logic         byte_ok;
  logic         close_now;
  logic         drop;
  logic         drop_close;
  logic         pend_close;
  udp_desc_t    pend_desc;
  logic [DAW:0] data_free;
  logic         afull_next;

  gbe_udp_fifo #(.WIDTH(8), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk     (app_clk),
    .rst_n   (app_rst_n),
    .wr_en   (byte_ok),
    .wr_data (app_tx_data),
    .rd_en   (data_rd),
    .rd_data (data_head),
    .full    (data_full),
    .count   (data_count)
  );

  gbe_udp_fifo #(.WIDTH($bits(udp_desc_t)), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
    .clk     (app_clk),
    .rst_n   (app_rst_n),
    .wr_en   (hdr_wr),
    .wr_data (hdr_wr_data),
    .rd_en   (hdr_rd),
    .rd_data (hdr_head),
    .full    (hdr_full),
    .count   (hdr_count)
  );

  assign hdr_empty = (hdr_count == '0);

  // A pending close (eof on a dropped byte) blocks new bytes until its
  // descriptor is pushed, so at most one descriptor is written per cycle.
  assign byte_ok    = app_tx_dvld && !data_full && !hdr_full && !pend_close;
  assign len_inc    = in_len + 16'd1;
  assign close_now  = byte_ok && (app_tx_eof || (len_inc == 16'(MAX_PAYLOAD)));
  assign drop       = app_tx_dvld && !byte_ok;
  assign drop_close = drop && app_tx_eof && (in_len != '0);
  assign hdr_wr     = close_now || (pend_close && !hdr_full);
  assign data_free  = DATA_DEPTH_W - data_count;
  assign afull_next = (int'(data_free) <= AFULL_MARGIN) || (int'(hdr_count) >= HDR_DEPTH - 1);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    hdr_wr_data = pend_desc;
    if (!pend_close) begin
      hdr_wr_data.destip   = app_tx_destip;
      hdr_wr_data.destport = app_tx_destport;
      hdr_wr_data.len      = len_inc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      in_len          <= '0;
      pend_close      <= 1'b0;
      pend_desc       <= '0;
      app_tx_overflow <= 1'b0;
      app_tx_afull    <= 1'b0;
    end else begin
      app_tx_overflow <= drop;
      app_tx_afull    <= afull_next;
      if (drop_close) begin
        pend_close         <= 1'b1;
        pend_desc.destip   <= app_tx_destip;
        pend_desc.destport <= app_tx_destport;
        pend_desc.len      <= in_len;
        in_len             <= '0;
      end else begin
        if (pend_close && !hdr_full) pend_close <= 1'b0;
        if (close_now)    in_len <= '0;
        else if (byte_ok) in_len <= len_inc;
      end
    end
  end

  // ---------------- egress ----------------
  tx_state_e              state;
  udp_desc_t              tx_desc;
  logic [15:0]            tx_csum;
  logic [15:0]            ip_id;
  logic [15:0]            idx;
  logic [15:0]            nxt;
  logic [15:0]            pay_end;
  logic [15:0]            tot_len;
  logic [15:0]            udp_len;
  logic [HDR_LEN*8-1:0]   hdr_vec;
  logic [7:0]             hdr_bytes [HDR_LEN];

  assign nxt     = idx + 16'd1;
  assign pay_end = 16'(HDR_LEN) + tx_desc.len;
  assign tot_len = tx_desc.len + IP_UDP_OVH;
  assign udp_len = tx_desc.len + UDP_OVH;
  assign hdr_rd  = (state == ST_IDLE) && !hdr_empty;
  assign data_rd = ((state == ST_HEADER) && (idx == 16'(HDR_LEN - 1))) ||
                   ((state == ST_PAYLOAD) && (nxt < pay_end));

  always_comb begin
    hdr_vec = {DEST_MAC, LOCAL_MAC, ETHERTYPE_IPV4,
               8'h45, 8'h00, tot_len, ip_id, 16'h4000, 8'h40, IP_PROTO_UDP,
               tx_csum, LOCAL_IP, tx_desc.destip,
               LOCAL_PORT, tx_desc.destport, udp_len, 16'h0000};
    for (int i = 0; i < HDR_LEN; i++) hdr_bytes[i] = hdr_vec[(HDR_LEN-1-i)*8 +: 8];
  end

  // Output byte is registered: each cycle loads the byte at index nxt, so the
  // MAC sees byte 0 throughout ACKWAIT and byte 1 right after the ack edge.
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      state       <= ST_IDLE;
      tx_desc     <= '0;
      tx_csum     <= '0;
      ip_id       <= '0;
      idx         <= '0;
      mac_tx_data <= '0;
      mac_tx_dvld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mac_tx_dvld <= 1'b0;
          mac_tx_data <= '0;
          if (!hdr_empty) begin
            tx_desc     <= hdr_head;
            tx_csum     <= ip_csum(ip_id, hdr_head.len + IP_UDP_OVH, LOCAL_IP, hdr_head.destip);
            idx         <= '0;
            mac_tx_dvld <= 1'b1;
            mac_tx_data <= DEST_MAC[47:40];
            state       <= ST_ACKWAIT;
          end
        end
        ST_ACKWAIT: begin
          if (mac_tx_ack) begin
            idx         <= nxt;
            mac_tx_data <= hdr_bytes[nxt[5:0]];
            state       <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          idx <= nxt;
          if (idx == 16'(HDR_LEN - 1)) begin
            mac_tx_data <= data_head;
            state       <= ST_PAYLOAD;
          end else begin
            mac_tx_data <= hdr_bytes[nxt[5:0]];
          end
        end
        ST_PAYLOAD, ST_PAD: begin
          if ((state == ST_PAYLOAD) && (nxt < pay_end)) begin
            idx         <= nxt;
            mac_tx_data <= data_head;
          end else if (nxt < 16'(MIN_FRAME)) begin
            idx         <= nxt;
            mac_tx_data <= '0;
            state       <= ST_PAD;
          end else begin
            mac_tx_dvld <= 1'b0;
            mac_tx_data <= '0;
            ip_id       <= ip_id + 16'd1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbe_udp_core.sv
// Directed bench for gbe_udp_core: a MAC model captures frames and compares
// them against frames queued by a reference model as stimulus is driven.
module tb_gbe_udp_core;

  logic        app_clk = 1'b0;
  logic        app_rst_n = 1'b0;
  logic [7:0]  app_tx_data = '0;
  logic        app_tx_dvld = 1'b0;
  logic        app_tx_eof = 1'b0;
  logic [31:0] app_tx_destip = 32'hc0a84001;
  logic [15:0] app_tx_destport = 16'hbeef;
  logic        app_tx_afull;
  logic        app_tx_overflow;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld;
  logic        mac_tx_ack = 1'b0;

  gbe_udp_core dut (
    .app_clk         (app_clk),
    .app_rst_n       (app_rst_n),
    .app_tx_data     (app_tx_data),
    .app_tx_dvld     (app_tx_dvld),
    .app_tx_eof      (app_tx_eof),
    .app_tx_destip   (app_tx_destip),
    .app_tx_destport (app_tx_destport),
    .app_tx_afull    (app_tx_afull),
    .app_tx_overflow (app_tx_overflow),
    .mac_tx_data     (mac_tx_data),
    .mac_tx_dvld     (mac_tx_dvld),
    .mac_tx_ack      (mac_tx_ack)
  );

  always #5 app_clk = ~app_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          frames_done = 0;
  int          ovf_cnt = 0;
  int unsigned ack_delay = 1;
  int unsigned wait_cnt = 0;
  bit          acked = 1'b0;
  logic [15:0] exp_id = '0;
  logic [7:0]  pend[$];
  logic [7:0]  exp_bytes[$];
  int          exp_len[$];
  logic [7:0]  frame[$];
  logic [7:0]  last_frame[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: builds the whole expected frame from the pending payload.
  task automatic expect_frame();
    logic [7:0]  h [42];
    logic [15:0] len16, tot, udp, csum;
    int unsigned sum;
    len16 = 16'(pend.size());
    tot   = len16 + 16'd28;
    udp   = len16 + 16'd8;
    h = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff,
          8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'h08, 8'h00,
          8'h45, 8'h00, tot[15:8], tot[7:0], exp_id[15:8], exp_id[7:0],
          8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
          8'd100, 8'd101, 8'd102, 8'd103,
          app_tx_destip[31:24], app_tx_destip[23:16], app_tx_destip[15:8], app_tx_destip[7:0],
          8'hde, 8'had, app_tx_destport[15:8], app_tx_destport[7:0],
          udp[15:8], udp[7:0], 8'h00, 8'h00};
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {16'h0, h[i], h[i+1]};
    while (sum > 32'hffff) sum = (sum & 32'hffff) + (sum >> 16);
    csum  = ~sum[15:0];
    h[24] = csum[15:8];
    h[25] = csum[7:0];
    for (int i = 0; i < 42; i++) exp_bytes.push_back(h[i]);
    foreach (pend[i]) exp_bytes.push_back(pend[i]);
    for (int i = 42 + pend.size(); i < 60; i++) exp_bytes.push_back(8'h00);
    exp_len.push_back((42 + pend.size() < 60) ? 60 : 42 + pend.size());
    exp_id = exp_id + 16'd1;
    pend.delete();
  endtask

  task automatic score_frame();
    int len, bad, first;
    logic [7:0] e;
    if (exp_len.size() == 0) begin
      check("unexpected_frame", 64'(frame.size()), 64'd0);
    end else begin
      len = exp_len.pop_front();
      check("frame_len", 64'(frame.size()), 64'(len));
      bad = 0;
      first = -1;
      for (int i = 0; i < len; i++) begin
        e = exp_bytes.pop_front();
        if (i >= frame.size() || frame[i] !== e) begin
          if (first < 0) first = i;
          bad++;
        end
      end
      if (bad != 0) $display("frame %0d: first bad byte at %0d", frames_done, first);
      check("frame_bytes_bad", 64'(bad), 64'd0);
    end
    last_frame = frame;
    frames_done++;
  endtask

  // MAC model: holds off ack for ack_delay cycles of dvld, then captures bytes.
  always @(negedge app_clk) begin
    if (!app_rst_n) begin
      acked      = 1'b0;
      wait_cnt   = 0;
      mac_tx_ack = 1'b0;
      frame.delete();
    end else begin
      if (app_tx_overflow) ovf_cnt++;
      if (acked) begin
        mac_tx_ack = 1'b0;
        if (mac_tx_dvld) frame.push_back(mac_tx_data);
        else begin
          score_frame();
          acked    = 1'b0;
          wait_cnt = 0;
        end
      end else if (mac_tx_dvld) begin
        check("ackwait_byte0", 64'(mac_tx_data), 64'hff);
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          mac_tx_ack = 1'b1;
          frame.delete();
          frame.push_back(mac_tx_data);
          acked = 1'b1;
        end
      end
    end
  end

  task automatic drive_byte(input logic [7:0] d, input logic eof);
    @(negedge app_clk);
    app_tx_data = d;
    app_tx_dvld = 1'b1;
    app_tx_eof  = eof;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge app_clk);
      app_tx_dvld = 1'b0;
      app_tx_eof  = 1'b0;
    end
  endtask

  task automatic send_pkt(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      drive_byte(b, i == n - 1);
      pend.push_back(b);
    end
    expect_frame();
  endtask

  task automatic wait_frames(input int target, input string tag);
    int cyc = 0;
    while (frames_done < target && cyc < 20000) begin
      @(negedge app_clk);
      cyc++;
    end
    if (frames_done < target) check(tag, 64'(frames_done), 64'(target));
  endtask

  function automatic logic [15:0] fld16(input int off);
    return {last_frame[off], last_frame[off+1]};
  endfunction

  initial begin
    logic [7:0] b;
    int base, cyc;

    // Reset state
    #12;
    check("rst_afull", 64'(app_tx_afull), 64'd0);
    check("rst_overflow", 64'(app_tx_overflow), 64'd0);
    check("rst_dvld", 64'(mac_tx_dvld), 64'd0);
    check("rst_data", 64'(mac_tx_data), 64'd0);
    @(negedge app_clk);
    app_rst_n = 1'b1;
    idle(3);

    // Two back-to-back 256-byte packets, ack one cycle after dvld
    ack_delay = 1;
    send_pkt(256);
    send_pkt(256);
    idle(1);
    wait_frames(1, "timeout_frame1");
    check("f1_size", 64'(last_frame.size()), 64'd298);
    check("f1_ethertype", 64'(fld16(12)), 64'h0800);
    check("f1_totlen", 64'(fld16(16)), 64'h011c);
    check("f1_id", 64'(fld16(18)), 64'h0000);
    check("f1_csum", 64'(fld16(24)), 64'h6e5b);
    check("f1_srcip", 64'({fld16(26), fld16(28)}), 64'h64656667);
    check("f1_dstip", 64'({fld16(30), fld16(32)}), 64'hc0a84001);
    check("f1_srcport", 64'(fld16(34)), 64'hdead);
    check("f1_dstport", 64'(fld16(36)), 64'hbeef);
    check("f1_udplen", 64'(fld16(38)), 64'h0108);
    wait_frames(2, "timeout_frame2");
    check("f2_id", 64'(fld16(18)), 64'h0001);
    check("f2_csum", 64'(fld16(24)), 64'h6e5a);

    // Ack delayed by 10 cycles: byte 0 held (checked by the MAC model)
    ack_delay = 10;
    send_pkt(256);
    idle(1);
    wait_frames(3, "timeout_frame3");

    // Ack held low while streaming 9 x 256 bytes into a 2048-byte buffer
    ack_delay = 32'hffff_ffff;
    ovf_cnt = 0;
    check("pre_fill_afull", 64'(app_tx_afull), 64'd0);
    for (int k = 1; k <= 2304; k++) begin
      b = 8'($urandom);
      drive_byte(b, (k % 256) == 0);
      if (k <= 2048) begin
        pend.push_back(b);
        if ((k % 256) == 0) expect_frame();
      end
      if (k == 1983) begin
        idle(2);
        check("afull_at_65_free", 64'(app_tx_afull), 64'd0);
      end
      if (k == 1984) begin
        idle(2);
        check("afull_at_64_free", 64'(app_tx_afull), 64'd1);
      end
    end
    idle(2);
    check("overflow_pulses", 64'(ovf_cnt), 64'd256);
    check("held_frames_done", 64'(frames_done), 64'd3);
    ack_delay = 1;
    wait_frames(11, "timeout_drain");
    idle(5);
    check("afull_after_drain", 64'(app_tx_afull), 64'd0);

    // 1500 bytes: forced close at 1472, remainder closed by eof
    for (int k = 1; k <= 1500; k++) begin
      b = 8'($urandom);
      drive_byte(b, k == 1500);
      pend.push_back(b);
      if (k == 1472 || k == 1500) expect_frame();
    end
    idle(1);
    wait_frames(13, "timeout_split");
    check("split_len2", 64'(last_frame.size()), 64'd70);
    check("pending_expected", 64'(exp_len.size()), 64'd0);

    // Reset in the middle of a frame
    for (int k = 1; k <= 100; k++) drive_byte(8'($urandom), k == 100);
    idle(1);
    cyc = 0;
    while (!(acked && frame.size() > 60) && cyc < 2000) begin
      @(negedge app_clk);
      cyc++;
    end
    check("midframe_reached", 64'(acked), 64'd1);
    #2;
    app_rst_n = 1'b0;
    #1;
    check("midrst_dvld", 64'(mac_tx_dvld), 64'd0);
    check("midrst_data", 64'(mac_tx_data), 64'd0);
    repeat (3) @(negedge app_clk);
    app_rst_n = 1'b1;
    exp_id = '0;
    base = frames_done;
    idle(20);
    check("post_rst_dvld", 64'(mac_tx_dvld), 64'd0);
    check("post_rst_frames", 64'(frames_done), 64'(base));

    // 4-byte packet after reset: padded to 60, id restarted at 0
    send_pkt(4);
    idle(1);
    wait_frames(base + 1, "timeout_pad");
    check("pad_size", 64'(last_frame.size()), 64'd60);
    check("pad_totlen", 64'(fld16(16)), 64'h0020);
    check("pad_udplen", 64'(fld16(38)), 64'h000c);
    check("pad_id", 64'(fld16(18)), 64'h0000);
    check("final_pending", 64'(exp_len.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
